spm_asin_search: RTL and testbench

- Sequential inverse of the quantized sin(pi·x) function used by the spm benchmark family.
- Given an unsigned target T, it returns the largest x in [0, 0.5) whose quantized sine does not exceed T.
- Algorithm: MSB-first bisection, testing one candidate bit per clock against a combinational sine evaluator.
- Sits next to the sin(pi·x) networks as their functional inverse, and serves as a bench/golden block for them.

---
 rtl/spm_asin_pkg.sv | 28 ++
 rtl/spm_sin_eval.sv | 29 ++
 rtl/spm_asin_search.sv | 101 ++++++++++
 tb/tb_spm_asin_search.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/spm_asin_pkg.sv
// Shared types and constants for the spm sin(pi*x) inverse search.
// SIN_Q holds round_half_up(255 * sin(pi * x / 256)) for x = 0..127.
package spm_asin_pkg;

  localparam int SPM_W = 8;
  localparam int SPM_N = 8;
  localparam int XMAX  = (1 << (SPM_W - 1)) - 1;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  localparam logic [SPM_N-1:0] SIN_FULL = '1;

  localparam logic [SPM_N-1:0] SIN_Q [0:XMAX] = '{
      0,   3,   6,   9,  13,  16,  19,  22,  25,  28,  31,  34,  37,  41,  44,  47,
     50,  53,  56,  59,  62,  65,  68,  71,  74,  77,  80,  83,  86,  89,  92,  95,
     98, 100, 103, 106, 109, 112, 115, 117, 120, 123, 126, 128, 131, 134, 136, 139,
    142, 144, 147, 149, 152, 154, 157, 159, 162, 164, 167, 169, 171, 174, 176, 178,
    180, 183, 185, 187, 189, 191, 193, 195, 197, 199, 201, 203, 205, 207, 208, 210,
    212, 214, 215, 217, 219, 220, 222, 223, 225, 226, 228, 229, 231, 232, 233, 234,
    236, 237, 238, 239, 240, 241, 242, 243, 244, 245, 246, 247, 247, 248, 249, 249,
    250, 251, 251, 252, 252, 253, 253, 253, 254, 254, 254, 255, 255, 255, 255, 255
  };

endpackage

// File: rtl/spm_sin_eval.sv
// Combinational quantized sin(pi*x/2^W) evaluator, table based.
// The upper half-period is folded onto the table so every input code has a defined value.
module spm_sin_eval
  import spm_asin_pkg::*;
#(
  parameter int W = SPM_W,
  parameter int N = SPM_N
) (
  input  logic [W-1:0] x,
  output logic [N-1:0] y
);

  logic [W-2:0] fold;

  // NOTE: the table is a constant ROM, so there is nothing to reset here.
  always_comb begin
    fold = x[W-2:0];
    if (x[W-1]) begin
      // sin(pi/2 + d) = sin(pi/2 - d): index 2^(W-1) - low bits
      fold = '0 - x[W-2:0];
    end
    if (x[W-1] && (x[W-2:0] == '0)) begin
      y = SIN_FULL;
    end else begin
      y = SIN_Q[fold];
    end
  end

endmodule

// File: rtl/spm_asin_search.sv
// MSB-first bisection inverse of sin_q: returns the largest x < 2^(W-1)
// with sin_q(x) <= t, one candidate bit per clock.
module spm_asin_search
  import spm_asin_pkg::*;
#(
  parameter int W = SPM_W,
  parameter int N = SPM_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] t,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] x,
  output logic         exact
);

  localparam int            IW      = $clog2(W);
  localparam logic [IW-1:0] IDX_TOP = IW'(W - 2);

  state_t        state_q, state_d;
  logic [W-1:0]  r_q, r_d;
  logic [N-1:0]  t_q, t_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  cand;
  logic [W-1:0]  eval_in;
  logic [N-1:0]  sin_val;

  assign cand = r_q | (W'(1) << idx_q);

  // One evaluator serves both the search compare and the final exact check.
  assign eval_in = (state_q == DONE) ? r_q : cand;

  spm_sin_eval #(
    .W (W),
    .N (N)
  ) u_eval (
    .x (eval_in),
    .y (sin_val)
  );

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    t_d       = t_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    exact     = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          t_d     = t;
          r_d     = '0;
          idx_d   = IDX_TOP;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (sin_val <= t_q) begin
          r_d = cand;
        end
        if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        exact     = (sin_val == t_q);
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      t_q     <= '0;
      idx_q   <= IDX_TOP;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      t_q     <= t_d;
      idx_q   <= idx_d;
    end
  end

  assign x = r_q;

endmodule

// File: tb/tb_spm_asin_search.sv
// Directed and swept checks of spm_asin_search against a real-valued sine model.
module tb_spm_asin_search;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       in_valid  = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] t         = 8'd0;
  logic       in_ready;
  logic       out_valid;
  logic       exact;
  logic [7:0] x;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] t;
    logic [7:0] x;
    logic       exact;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  spm_asin_search dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .t         (t),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .exact     (exact)
  );

  function automatic int sin_ref(input int xi);
    return int'($floor(255.0 * $sin(3.14159265358979323846 * real'(xi) / 256.0) + 0.5));
  endfunction

  function automatic exp_t model(input logic [7:0] tv);
    exp_t e;
    e.t = tv;
    e.x = 8'd0;
    for (int i = 0; i < 128; i++) begin
      if (sin_ref(i) <= int'(tv)) e.x = 8'(i);
    end
    e.exact = (sin_ref(int'(e.x)) == int'(tv));
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one request from a negedge, wait for the result, optionally stall
  // (and poke in_valid while stalled), then compare against the scoreboard.
  task automatic transact(input logic [7:0] tv, input int stall, input bit poke,
                          output logic [7:0] xo, output logic eo);
    int   n;
    exp_t e;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle_ready", in_ready, 1);
    in_valid = 1'b1;
    t        = tv;
    sb.push_back(model(tv));
    @(negedge clk);
    in_valid = 1'b0;
    t        = 8'($urandom);
    check("busy_ready", in_ready, 0);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, 7);
    xo = x;
    eo = exact;
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        in_valid = 1'b1;
        t        = ~tv;
      end
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_x", x, xo);
      check("hold_exact", exact, eo);
      if (poke) check("hold_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    e = sb.pop_front();
    check("x", x, e.x);
    check("exact", exact, e.exact);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drop_valid", out_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] xo;
    logic       eo;
    logic [7:0] prev;
    int         seen;

    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_x", x, 0);
    check("rst_exact", exact, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    transact(8'd0, 0, 1'b0, xo, eo);
    check("t0_x", xo, 0);
    check("t0_exact", eo, 1);
    transact(8'd255, 0, 1'b0, xo, eo);
    check("t255_x", xo, 127);
    check("t255_exact", eo, 1);
    transact(8'd1, 0, 1'b0, xo, eo);
    check("t1_x", xo, 0);
    check("t1_exact", eo, 0);
    transact(8'd128, 0, 1'b0, xo, eo);
    check("t128_x", xo, 43);
    check("t128_exact", eo, 1);
    transact(8'd127, 0, 1'b0, xo, eo);
    check("t127_x", xo, 42);
    check("t127_exact", eo, 0);

    // Backpressure with ignored requests, then a normal follow-up request.
    transact(8'd100, 5, 1'b1, xo, eo);
    transact(8'd180, 0, 1'b0, xo, eo);
    check("t180_x", xo, 64);

    // Abort during the third SEARCH cycle.
    in_valid = 1'b1;
    t        = 8'd230;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_x", x, 0);
    check("abort_exact", exact, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    check("abort_no_valid", seen, 0);
    transact(8'd200, 0, 1'b0, xo, eo);

    prev = 8'd0;
    for (int tv = 0; tv < 256; tv++) begin
      transact(8'(tv), int'($urandom_range(0, 3)), 1'b0, xo, eo);
      check("monotonic", (xo >= prev), 1);
      prev = xo;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
